// File: rtl/alu_issue_unit.sv
// -----------------------------------------------------------------------------
// alu_issue_unit
//
// Issue/collect front end for the 32-bit ALU. Takes one decoded R-type
// instruction at a time. It translates the funct code into the 4-bit ALU
// operation and drives registered operands to the ALU. It then waits a fixed
// number of cycles (longer for mul), captures the ALU result and offers it
// downstream together with the instruction tag.
//
// Handshakes: both the input and output sides use valid/ready. A transfer
// happens on a rising clk edge where valid && ready. The producer holds its
// payload stable while valid && !ready. The unit holds out_valid and the
// out_* payload stable until out_ready is seen.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   in_valid/in_ready   instruction handshake
//   in_funct            R-type funct code
//   in_rs_val/in_rt_val register operands
//   in_shamt            shift amount
//   in_tag              instruction tag
//   alu_operand1/2      registered operands to the ALU
//   alu_operation       registered 4-bit ALU op code
//   alu_result          combinational result back from the ALU
//   out_valid/out_ready result handshake
//   out_result          captured result (0 for illegal funct)
//   out_tag             tag of the completed instruction
//   out_illegal         funct was not a supported code
//   op_count            completed output handshakes, wraps at 16 bits
//
// The FSM state register is the signal named "state" (IDLE/EXEC/DONE), so
// checkers can bind to it directly.
// -----------------------------------------------------------------------------
module alu_issue_unit #(
   parameter int TAG_W      = 4,
   parameter int MUL_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       in_funct,
   input  logic [31:0]      in_rs_val,
   input  logic [31:0]      in_rt_val,
   input  logic [4:0]       in_shamt,
   input  logic [TAG_W-1:0] in_tag,
   output logic [31:0]      alu_operand1,
   output logic [31:0]      alu_operand2,
   output logic [3:0]       alu_operation,
   input  logic [31:0]      alu_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal,
   output logic [15:0]      op_count
);

   // R-type funct codes accepted by the unit
   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_NOR = 6'h27;
   localparam logic [5:0] F_SLL = 6'h00;
   localparam logic [5:0] F_SRL = 6'h02;
   localparam logic [5:0] F_MUL = 6'h18;

   // ALU operation codes
   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_AND = 4'b0001;
   localparam logic [3:0] OP_OR  = 4'b0010;
   localparam logic [3:0] OP_NOR = 4'b0011;
   localparam logic [3:0] OP_SLL = 4'b0100;
   localparam logic [3:0] OP_SRL = 4'b0101;
   localparam logic [3:0] OP_MUL = 4'b0110;
   localparam logic [3:0] OP_ILL = 4'b1111;

   // Extra EXEC cycles for mul. With cnt loaded to MUL_CYCLES-1 the result
   // is captured MUL_CYCLES edges after the accept edge.
   localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [3:0]       cnt;
   logic             illegal_q;
   logic [TAG_W-1:0] tag_q;

   // Decode of the instruction currently offered on the input side
   logic [3:0]  dec_op;
   logic        dec_illegal;
   logic        dec_shift;
   logic        dec_mul;
   logic [31:0] dec_op1;
   logic [31:0] dec_op2;
   logic        accept;

   always_comb begin
      dec_op      = OP_ILL;
      dec_illegal = 1'b1;
      dec_shift   = 1'b0;
      dec_mul     = 1'b0;
      case (in_funct)
         F_ADD: begin dec_op = OP_ADD; dec_illegal = 1'b0; end
         F_AND: begin dec_op = OP_AND; dec_illegal = 1'b0; end
         F_OR:  begin dec_op = OP_OR;  dec_illegal = 1'b0; end
         F_NOR: begin dec_op = OP_NOR; dec_illegal = 1'b0; end
         F_SLL: begin dec_op = OP_SLL; dec_illegal = 1'b0; dec_shift = 1'b1; end
         F_SRL: begin dec_op = OP_SRL; dec_illegal = 1'b0; dec_shift = 1'b1; end
         F_MUL: begin dec_op = OP_MUL; dec_illegal = 1'b0; dec_mul   = 1'b1; end
         default: begin end
      endcase
   end

   // Shifts operate on rt by shamt. Everything else, illegal included,
   // passes rs/rt straight through.
   always_comb begin
      dec_op1 = dec_shift ? in_rt_val : in_rs_val;
      dec_op2 = dec_shift ? {27'b0, in_shamt} : in_rt_val;
   end

   // In DONE a new instruction can only enter on the same edge that the
   // current result leaves, so in_ready follows out_ready there.
   always_comb begin
      in_ready = 1'b0;
      case (state)
         IDLE:    in_ready = 1'b1;
         DONE:    in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
   end

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= 4'd0;
         illegal_q     <= 1'b0;
         tag_q         <= '0;
         alu_operand1  <= 32'd0;
         alu_operand2  <= 32'd0;
         alu_operation <= 4'd0;
         out_valid     <= 1'b0;
         out_result    <= 32'd0;
         out_tag       <= '0;
         out_illegal   <= 1'b0;
         op_count      <= 16'd0;
      end else begin
         // The alu_* registers change only here, so they hold their last
         // values between instructions.
         if (accept) begin
            alu_operand1  <= dec_op1;
            alu_operand2  <= dec_op2;
            alu_operation <= dec_op;
            illegal_q     <= dec_illegal;
            tag_q         <= in_tag;
            cnt           <= dec_mul ? MUL_LOAD : 4'd0;
         end

         case (state)
            IDLE: begin
               if (accept) begin
                  state <= EXEC;
               end
            end

            EXEC: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  // An illegal funct still runs through the ALU, but its
                  // result is discarded.
                  out_result  <= illegal_q ? 32'd0 : alu_result;
                  out_tag     <= tag_q;
                  out_illegal <= illegal_q;
                  out_valid   <= 1'b1;
                  state       <= DONE;
               end
            end

            DONE: begin
               if (out_ready) begin
                  op_count  <= op_count + 16'd1;
                  out_valid <= 1'b0;
                  state     <= accept ? EXEC : IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_unit
//
// Bench for alu_issue_unit. It contains a small reference ALU that answers
// alu_result from the DUT's alu_* outputs. A transaction-level model predicts
// the handshake timing and the result from the funct/rs/rt/shamt fields.
// A compare process checks the DUT against that model on every falling edge.
// Directed sequences add literal expectations on top of the model.
// -----------------------------------------------------------------------------
module tb_alu_issue_unit;

   localparam int TAG_W      = 4;
   localparam int MUL_CYCLES = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic             in_valid;
   logic             in_ready;
   logic [5:0]       in_funct;
   logic [31:0]      in_rs_val;
   logic [31:0]      in_rt_val;
   logic [4:0]       in_shamt;
   logic [TAG_W-1:0] in_tag;
   logic [31:0]      alu_operand1;
   logic [31:0]      alu_operand2;
   logic [3:0]       alu_operation;
   logic [31:0]      alu_result;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_result;
   logic [TAG_W-1:0] out_tag;
   logic             out_illegal;
   logic [15:0]      op_count;

   alu_issue_unit #(.TAG_W(TAG_W), .MUL_CYCLES(MUL_CYCLES)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_funct(in_funct),
      .in_rs_val(in_rs_val),
      .in_rt_val(in_rt_val),
      .in_shamt(in_shamt),
      .in_tag(in_tag),
      .alu_operand1(alu_operand1),
      .alu_operand2(alu_operand2),
      .alu_operation(alu_operation),
      .alu_result(alu_result),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_result(out_result),
      .out_tag(out_tag),
      .out_illegal(out_illegal),
      .op_count(op_count)
   );

   // Reference ALU. Unknown op codes return garbage, so the DUT has to force
   // the result of an illegal instruction to zero itself.
   always_comb begin
      case (alu_operation)
         4'b0000: alu_result = alu_operand1 + alu_operand2;
         4'b0001: alu_result = alu_operand1 & alu_operand2;
         4'b0010: alu_result = alu_operand1 | alu_operand2;
         4'b0011: alu_result = ~(alu_operand1 | alu_operand2);
         4'b0100: alu_result = alu_operand1 << alu_operand2[4:0];
         4'b0101: alu_result = alu_operand1 >> alu_operand2[4:0];
         4'b0110: alu_result = alu_operand1 * alu_operand2;
         default: alu_result = 32'hDEAD_BEEF;
      endcase
   end

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- instruction-level model ----------------
   function automatic logic [3:0] f_op(input logic [5:0] f);
      case (f)
         6'h20:   return 4'b0000;
         6'h24:   return 4'b0001;
         6'h25:   return 4'b0010;
         6'h27:   return 4'b0011;
         6'h00:   return 4'b0100;
         6'h02:   return 4'b0101;
         6'h18:   return 4'b0110;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic bit f_shift(input logic [5:0] f);
      return (f == 6'h00) || (f == 6'h02);
   endfunction

   function automatic logic [31:0] f_res(input logic [5:0] f, input logic [31:0] rs,
                                         input logic [31:0] rt, input logic [4:0] sh);
      logic [63:0] prod;
      prod = 64'(rs) * 64'(rt);
      case (f)
         6'h20:   return rs + rt;
         6'h24:   return rs & rt;
         6'h25:   return rs | rt;
         6'h27:   return ~(rs | rt);
         6'h00:   return rt << sh;
         6'h02:   return rt >> sh;
         6'h18:   return prod[31:0];
         default: return 32'd0;
      endcase
   endfunction

   // Number of edges from accept until the result is visible
   function automatic int f_lat(input logic [5:0] f);
      return (f == 6'h18) ? MUL_CYCLES : 1;
   endfunction

   bit               chk_en = 1'b0;
   bit               m_pending;
   bit               m_valid;
   int               m_wait;
   logic [31:0]      m_res;
   logic [31:0]      m_op1;
   logic [31:0]      m_op2;
   logic [3:0]       m_op;
   logic [TAG_W-1:0] m_tag;
   logic             m_ill;
   logic [15:0]      m_count;

   always @(posedge clk) begin
      if (!rst_n) begin
         chk_en    <= 1'b1;
         m_pending <= 1'b0;
         m_valid   <= 1'b0;
         m_wait    <= 0;
         m_res     <= 32'd0;
         m_op1     <= 32'd0;
         m_op2     <= 32'd0;
         m_op      <= 4'd0;
         m_tag     <= '0;
         m_ill     <= 1'b0;
         m_count   <= 16'd0;
      end else begin
         if (m_valid && out_ready) begin
            m_valid   <= 1'b0;
            m_pending <= 1'b0;
            m_count   <= m_count + 16'd1;
         end else if (m_pending && !m_valid) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) m_valid <= 1'b1;
         end
         // A later non-blocking write wins, so a back-to-back accept
         // overrides the clear above.
         if (in_valid && (!m_pending || (m_valid && out_ready))) begin
            m_pending <= 1'b1;
            m_wait    <= f_lat(in_funct);
            m_op      <= f_op(in_funct);
            m_op1     <= f_shift(in_funct) ? in_rt_val : in_rs_val;
            m_op2     <= f_shift(in_funct) ? {27'b0, in_shamt} : in_rt_val;
            m_res     <= f_res(in_funct, in_rs_val, in_rt_val, in_shamt);
            m_ill     <= (f_op(in_funct) == 4'b1111);
            m_tag     <= in_tag;
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         check("mdl_in_ready", 32'(in_ready), 32'(!m_pending || (m_valid && out_ready)));
         check("mdl_out_valid", 32'(out_valid), 32'(m_valid));
         check("mdl_op_count", 32'(op_count), 32'(m_count));
         check("mdl_operand1", alu_operand1, m_op1);
         check("mdl_operand2", alu_operand2, m_op2);
         check("mdl_operation", 32'(alu_operation), 32'(m_op));
         if (m_valid) begin
            check("mdl_out_result", out_result, m_res);
            check("mdl_out_tag", 32'(out_tag), 32'(m_tag));
            check("mdl_out_illegal", 32'(out_illegal), 32'(m_ill));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Offer one instruction and return at accept edge + 1.
   task automatic issue(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [4:0] sh, input logic [TAG_W-1:0] tg);
      int   n;
      logic rdy;
      in_valid  = 1'b1;
      in_funct  = f;
      in_rs_val = rs;
      in_rt_val = rt;
      in_shamt  = sh;
      in_tag    = tg;
      n = 0;
      do begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         n++;
      end while (!rdy && n < 50);
      #1;
      in_valid = 1'b0;
      if (!rdy) check("issue_timeout", 32'(rdy), 32'd1);
   endtask

   // Directed table: funct, rs, rt, shamt and the hand-computed result
   logic [5:0]  t_f[5]   = '{6'h27, 6'h02, 6'h24, 6'h20, 6'h18};
   logic [31:0] t_rs[5]  = '{32'h0F0F_0000, 32'h1234_5678, 32'hFF00_FF00, 32'hFFFF_FFFF, 32'h0001_0000};
   logic [31:0] t_rt[5]  = '{32'h0000_00FF, 32'h8000_0000, 32'h0FF0_0FF0, 32'h0000_0002, 32'h0001_0001};
   logic [4:0]  t_sh[5]  = '{5'd0, 5'd31, 5'd0, 5'd0, 5'd0};
   logic [31:0] t_exp[5] = '{32'hF0F0_FF00, 32'h0000_0001, 32'h0F00_0F00, 32'h0000_0001, 32'h0001_0000};

   // ---------------- stimulus ----------------
   initial begin
      int n;
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_funct  = 6'h20;
      in_rs_val = 32'd1;
      in_rt_val = 32'd2;
      in_shamt  = 5'd0;
      in_tag    = 4'd1;
      out_ready = 1'b1;

      // Reset held two edges with an instruction offered
      repeat (2) @(posedge clk);
      #1;
      check("rst_operand1", alu_operand1, 32'd0);
      check("rst_operand2", alu_operand2, 32'd0);
      check("rst_operation", 32'(alu_operation), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_result", out_result, 32'd0);
      check("rst_out_tag", 32'(out_tag), 32'd0);
      check("rst_out_illegal", 32'(out_illegal), 32'd0);
      check("rst_op_count", 32'(op_count), 32'd0);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_nothing_taken", 32'(out_valid), 32'd0);
      step;

      // add: result visible one edge after accept
      issue(6'h20, 32'd5, 32'd7, 5'd0, 4'd3);
      @(negedge clk);
      check("add_e0_valid", 32'(out_valid), 32'd0);
      check("add_operation", 32'(alu_operation), 32'h0);
      @(negedge clk);
      check("add_e1_valid", 32'(out_valid), 32'd1);
      check("add_result", out_result, 32'd12);
      check("add_tag", 32'(out_tag), 32'd3);
      step;
      @(negedge clk);
      check("add_op_count", 32'(op_count), 32'd1);
      step;

      // sll: rt shifted by shamt, rs ignored
      issue(6'h00, 32'h0000_FFFF, 32'h1, 5'd4, 4'd5);
      @(negedge clk);
      check("sll_operand1", alu_operand1, 32'd1);
      check("sll_operand2", alu_operand2, 32'd4);
      check("sll_operation", 32'(alu_operation), 32'h4);
      @(negedge clk);
      check("sll_result", out_result, 32'h10);
      step;

      // mul: out_valid must stay low until MUL_CYCLES edges after accept
      issue(6'h18, 32'd6, 32'd7, 5'd0, 4'd6);
      for (int k = 0; k < MUL_CYCLES; k++) begin
         @(negedge clk);
         check("mul_early_valid", 32'(out_valid), 32'd0);
      end
      @(negedge clk);
      check("mul_valid", 32'(out_valid), 32'd1);
      check("mul_result", out_result, 32'd42);
      step;

      // Backpressure: result held for five cycles, then back-to-back or
      out_ready = 1'b0;
      issue(6'h20, 32'd100, 32'd23, 5'd0, 4'd9);
      @(negedge clk);
      repeat (5) begin
         @(negedge clk);
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_result", out_result, 32'd123);
         check("bp_tag", 32'(out_tag), 32'd9);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      step;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_funct  = 6'h25;
      in_rs_val = 32'hF0;
      in_rt_val = 32'h0F;
      in_shamt  = 5'd0;
      in_tag    = 4'd10;
      @(negedge clk);
      check("b2b_in_ready", 32'(in_ready), 32'd1);
      step;
      in_valid = 1'b0;
      @(negedge clk);
      check("b2b_exec_valid", 32'(out_valid), 32'd0);
      check("b2b_op_count", 32'(op_count), 32'd4);
      @(negedge clk);
      check("or_valid", 32'(out_valid), 32'd1);
      check("or_result", out_result, 32'hFF);
      check("or_tag", 32'(out_tag), 32'd10);
      step;

      // Remaining operations from the directed table
      for (int i = 0; i < 5; i++) begin
         issue(t_f[i], t_rs[i], t_rt[i], t_sh[i], 4'(i));
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!out_valid && n < 20);
         check("tbl_valid", 32'(out_valid), 32'd1);
         check("tbl_result", out_result, t_exp[i]);
         step;
      end

      // Illegal funct: op code 1111, flag set, result forced to zero
      issue(6'h3F, 32'd3, 32'd4, 5'd0, 4'd11);
      @(negedge clk);
      check("ill_operation", 32'(alu_operation), 32'hF);
      check("ill_operand1", alu_operand1, 32'd3);
      @(negedge clk);
      check("ill_valid", 32'(out_valid), 32'd1);
      check("ill_flag", 32'(out_illegal), 32'd1);
      check("ill_result", out_result, 32'd0);
      check("ill_tag", 32'(out_tag), 32'd11);
      step;

      // Reset at E1 of a mul abandons it
      issue(6'h18, 32'd6, 32'd7, 5'd0, 4'd12);
      rst_n = 1'b0;
      step;
      rst_n = 1'b1;
      repeat (MUL_CYCLES + 3) begin
         @(negedge clk);
         check("abort_valid", 32'(out_valid), 32'd0);
         check("abort_op_count", 32'(op_count), 32'd0);
         check("abort_in_ready", 32'(in_ready), 32'd1);
      end
      step;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
